// File: rtl/fifo_status_led_pkg.sv
// Shared types and default constants for the FIFO status LED controller.
// The SIM_* values shrink every timer so a simulation finishes in a few thousand cycles.
package fifo_status_led_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fault_state_t;

    localparam int DEF_SYNC_STAGE     = 2;
    localparam int DEF_CNT_WIDTH      = 20;
    localparam int DEF_FAST_WIDTH     = 17;
    localparam int DEF_STRETCH_CYCLES = 1000000;
    localparam int DEF_STRETCH_W      = 20;

    localparam int SIM_CNT_WIDTH      = 2;
    localparam int SIM_FAST_WIDTH     = 1;
    localparam int SIM_STRETCH_CYCLES = 5;
    localparam int SIM_STRETCH_W      = 3;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Saturating increment so the error counter never wraps back to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == ERR_COUNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/fifo_status_led_sync.sv
// Generic multi-flop synchroniser for one asynchronous level input.
// RST_VAL lets idle-high inputs (push buttons) come out of reset without a false edge.
module fifo_status_led_sync #(
    parameter int   SYNC_STAGE = 2,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGE-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= {SYNC_STAGE{RST_VAL}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGE-2:0], d};
        end
    end

    assign q = r_chain[SYNC_STAGE-1];

endmodule

// File: rtl/led_pulse_stretch.sv
// Keeps an LED lit for STRETCH_CYCLES extra cycles after its synchronised flag drops,
// so single-cycle FIFO full/empty events are still visible on the board.
module led_pulse_stretch #(
    parameter int STRETCH_CYCLES = 1000000,
    parameter int STRETCH_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic flag_s,
    output logic led
);

    logic [STRETCH_W-1:0] r_cnt;
    logic                 r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (flag_s) begin
            r_cnt <= STRETCH_W'(STRETCH_CYCLES);
            r_led <= 1'b1;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - STRETCH_W'(1);
            r_led <= 1'b1;
        end else begin
            r_led <= 1'b0;
        end
    end

    assign led = r_led;

endmodule

// File: rtl/fifo_status_led_ctrl.sv
// Board LED controller for the FIFO demo: heartbeat, sticky fault indicator with
// push-button clear, stretched full/empty LEDs and a saturating fault-entry counter.
module fifo_status_led_ctrl
    import fifo_status_led_pkg::*;
#(
    parameter int SYNC_STAGE     = DEF_SYNC_STAGE,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int FAST_WIDTH     = DEF_FAST_WIDTH,
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
    parameter int STRETCH_W      = DEF_STRETCH_W
) (
    input  logic       led_clk,
    input  logic       sys_rst,
    input  logic       pll_lock,
    input  logic       rdata_error_i,
    input  logic       fifo_full_i,
    input  logic       fifo_empty_i,
    input  logic       err_clr_n,
    output logic       led_blink,
    output logic       led_rdata_error,
    output logic       led_fifo_full,
    output logic       led_fifo_empty,
    output logic [7:0] err_count
);

    localparam int NUM_SYNC = 5;
    // Bit order: lock, error, full, empty, clear button (idle-high, so resets to 1).
    localparam logic [NUM_SYNC-1:0] SYNC_RST = 5'b10000;

    logic [NUM_SYNC-1:0] w_async;
    logic [NUM_SYNC-1:0] w_sync_s;
    logic                w_lock_s;
    logic                w_err_s;
    logic                w_full_s;
    logic                w_empty_s;
    logic                w_clr_n_s;

    assign w_async = {err_clr_n, fifo_empty_i, fifo_full_i, rdata_error_i, pll_lock};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SYNC; gi++) begin : g_sync
            fifo_status_led_sync #(
                .SYNC_STAGE (SYNC_STAGE),
                .RST_VAL    (SYNC_RST[gi])
            ) u_sync (
                .clk (led_clk),
                .rst (sys_rst),
                .d   (w_async[gi]),
                .q   (w_sync_s[gi])
            );
        end
    endgenerate

    assign w_lock_s  = w_sync_s[0];
    assign w_err_s   = w_sync_s[1];
    assign w_full_s  = w_sync_s[2];
    assign w_empty_s = w_sync_s[3];
    assign w_clr_n_s = w_sync_s[4];

    // Button falling edge, registered so the clear pulse is a clean single cycle.
    logic r_clr_d;
    logic r_clr_p;

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_clr_d <= 1'b1;
            r_clr_p <= 1'b0;
        end else begin
            r_clr_d <= w_clr_n_s;
            r_clr_p <= r_clr_d & ~w_clr_n_s;
        end
    end

    fault_state_t r_state;
    fault_state_t w_state_next;
    logic [7:0]   r_err_count;
    logic [7:0]   w_err_count_next;

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_RUN;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_next;
            r_err_count <= w_err_count_next;
        end
    end

    // A clear that coincides with a still-active error is ignored.
    always_comb begin
        w_state_next     = r_state;
        w_err_count_next = r_err_count;
        case (r_state)
            ST_RUN: begin
                if (w_err_s) begin
                    w_state_next     = ST_FAULT;
                    w_err_count_next = sat_inc8(r_err_count);
                end
            end
            ST_FAULT: begin
                if (r_clr_p && !w_err_s) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    logic [CNT_WIDTH-1:0] r_hb_cnt;
    logic                 r_blink;
    logic                 w_blink_tick;

    // Fault mode blinks from the low counter bits, i.e. much faster than the heartbeat.
    assign w_blink_tick = (r_state == ST_FAULT) ? (&r_hb_cnt[FAST_WIDTH-1:0]) : (&r_hb_cnt);

    always_ff @(posedge led_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_hb_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (!w_lock_s) begin
            r_hb_cnt <= '0;
            r_blink  <= 1'b0;
        end else begin
            r_hb_cnt <= r_hb_cnt + CNT_WIDTH'(1);
            if (w_blink_tick) begin
                r_blink <= ~r_blink;
            end
        end
    end

    led_pulse_stretch #(
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .STRETCH_W      (STRETCH_W)
    ) u_stretch_full (
        .clk    (led_clk),
        .rst    (sys_rst),
        .flag_s (w_full_s),
        .led    (led_fifo_full)
    );

    led_pulse_stretch #(
        .STRETCH_CYCLES (STRETCH_CYCLES),
        .STRETCH_W      (STRETCH_W)
    ) u_stretch_empty (
        .clk    (led_clk),
        .rst    (sys_rst),
        .flag_s (w_empty_s),
        .led    (led_fifo_empty)
    );

    assign led_blink       = r_blink;
    assign led_rdata_error = (r_state == ST_FAULT);
    assign err_count       = r_err_count;

endmodule

// File: tb/tb_fifo_status_led_ctrl.sv
// Bench for fifo_status_led_ctrl: directed and random stimulus against a cycle-level
// behavioural model built from delay queues, "cycles since last flag" ages and counters.
module tb_fifo_status_led_ctrl;
    import fifo_status_led_pkg::*;

    localparam int SS = 2;
    localparam int CW = SIM_CNT_WIDTH;
    localparam int FW = SIM_FAST_WIDTH;
    localparam int SC = SIM_STRETCH_CYCLES;
    localparam int SW = SIM_STRETCH_W;

    logic       led_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       rdata_error_i = 1'b0;
    logic       fifo_full_i = 1'b0;
    logic       fifo_empty_i = 1'b0;
    logic       err_clr_n = 1'b1;
    logic       led_blink;
    logic       led_rdata_error;
    logic       led_fifo_full;
    logic       led_fifo_empty;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 led_clk = ~led_clk;

    fifo_status_led_ctrl #(
        .SYNC_STAGE     (SS),
        .CNT_WIDTH      (CW),
        .FAST_WIDTH     (FW),
        .STRETCH_CYCLES (SC),
        .STRETCH_W      (SW)
    ) dut (
        .led_clk         (led_clk),
        .sys_rst         (sys_rst),
        .pll_lock        (pll_lock),
        .rdata_error_i   (rdata_error_i),
        .fifo_full_i     (fifo_full_i),
        .fifo_empty_i    (fifo_empty_i),
        .err_clr_n       (err_clr_n),
        .led_blink       (led_blink),
        .led_rdata_error (led_rdata_error),
        .led_fifo_full   (led_fifo_full),
        .led_fifo_empty  (led_fifo_empty),
        .err_count       (err_count)
    );

    // Reference model state
    bit q_lock[$];
    bit q_err[$];
    bit q_full[$];
    bit q_empty[$];
    bit q_clr[$];
    bit m_fault;
    bit m_blink;
    int m_count;
    int m_hb;
    int m_full_age;
    int m_empty_age;
    bit m_clr_prev1;
    bit m_clr_prev2;

    function automatic void model_reset();
        q_lock = {}; q_err = {}; q_full = {}; q_empty = {}; q_clr = {};
        for (int i = 0; i < SS; i++) begin
            q_lock.push_back(1'b0);
            q_err.push_back(1'b0);
            q_full.push_back(1'b0);
            q_empty.push_back(1'b0);
            q_clr.push_back(1'b1);
        end
        m_fault     = 1'b0;
        m_blink     = 1'b0;
        m_count     = 0;
        m_hb        = 0;
        m_full_age  = SC + 1;
        m_empty_age = SC + 1;
        m_clr_prev1 = 1'b1;
        m_clr_prev2 = 1'b1;
    endfunction

    // One led_clk edge: inputs reach the logic SS edges after being sampled.
    function automatic void model_step();
        bit lock_s, err_s, full_s, empty_s, clr_s, clr_req;
        int period;
        lock_s  = q_lock.pop_front();  q_lock.push_back(pll_lock);
        err_s   = q_err.pop_front();   q_err.push_back(rdata_error_i);
        full_s  = q_full.pop_front();  q_full.push_back(fifo_full_i);
        empty_s = q_empty.pop_front(); q_empty.push_back(fifo_empty_i);
        clr_s   = q_clr.pop_front();   q_clr.push_back(err_clr_n);

        clr_req     = m_clr_prev2 && !m_clr_prev1;
        m_clr_prev2 = m_clr_prev1;
        m_clr_prev1 = clr_s;

        if (!lock_s) begin
            m_hb    = 0;
            m_blink = 1'b0;
        end else begin
            period = m_fault ? (1 << FW) : (1 << CW);
            if ((m_hb % period) == period - 1) m_blink = !m_blink;
            m_hb = (m_hb + 1) % (1 << CW);
        end

        if (!m_fault) begin
            if (err_s) begin
                m_fault = 1'b1;
                if (m_count < 255) m_count++;
            end
        end else if (clr_req && !err_s) begin
            m_fault = 1'b0;
        end

        m_full_age  = full_s  ? 0 : ((m_full_age  > SC) ? SC + 1 : m_full_age + 1);
        m_empty_age = empty_s ? 0 : ((m_empty_age > SC) ? SC + 1 : m_empty_age + 1);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("led_blink",       {7'd0, led_blink},       {7'd0, m_blink});
        check("led_rdata_error", {7'd0, led_rdata_error}, {7'd0, m_fault});
        check("led_fifo_full",   {7'd0, led_fifo_full},   {7'd0, (m_full_age <= SC)});
        check("led_fifo_empty",  {7'd0, led_fifo_empty},  {7'd0, (m_empty_age <= SC)});
        check("err_count",       err_count,               8'(m_count));
    endtask

    task automatic tick();
        @(posedge led_clk);
        if (!sys_rst) model_step();
        @(negedge led_clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 sys_rst = 1'b1;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge led_clk);
        sys_rst = 1'b0;
    endtask

    int  toggles;
    int  lit;
    logic prev;

    initial begin
        model_reset();
        pll_lock = 1'b1;
        repeat (2) @(negedge led_clk);
        check_all();
        $display("reset: outputs checked while sys_rst held");
        sys_rst = 1'b0;

        // Heartbeat
        repeat (12) tick();
        toggles = 0; prev = led_blink;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (led_blink !== prev) toggles++;
            prev = led_blink;
        end
        check("run_blink_toggles_in_8", 8'(toggles), 8'd2);
        $display("lock: %0d heartbeat toggles in 8 cycles", toggles);
        pll_lock = 1'b0;
        repeat (3) tick();
        check("blink_after_unlock", {7'd0, led_blink}, 8'd0);
        $display("unlock: led_blink=%0b", led_blink);
        pll_lock = 1'b1;
        repeat (4) tick();

        // Stretch: 1-cycle full pulse, 10-cycle empty pulse
        fifo_full_i = 1'b1;
        tick();
        fifo_full_i = 1'b0;
        lit = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 1) check("full_lit_at_3", {7'd0, led_fifo_full}, 8'd1);
            if (led_fifo_full) lit++;
        end
        check("full_lit_cycles", 8'(lit), 8'd6);
        $display("stretch full: lit %0d cycles", lit);
        fifo_empty_i = 1'b1;
        lit = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) fifo_empty_i = 1'b0;
            tick();
            if (led_fifo_empty) lit++;
        end
        check("empty_lit_cycles", 8'(lit), 8'd15);
        $display("stretch empty: lit %0d cycles", lit);

        // Fault entry
        rdata_error_i = 1'b1;
        tick();
        rdata_error_i = 1'b0;
        repeat (2) tick();
        check("fault_entry_led", {7'd0, led_rdata_error}, 8'd1);
        check("fault_entry_count", err_count, 8'd1);
        toggles = 0; prev = led_blink;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (led_blink !== prev) toggles++;
            prev = led_blink;
        end
        check("fault_blink_toggles_in_8", 8'(toggles), 8'd4);
        $display("fault: led=%0b count=%0d fast toggles=%0d", led_rdata_error, err_count, toggles);

        // Clear arbitration
        rdata_error_i = 1'b1;
        err_clr_n = 1'b0;
        repeat (6) tick();
        check("clear_blocked_led", {7'd0, led_rdata_error}, 8'd1);
        check("clear_blocked_count", err_count, 8'd1);
        err_clr_n = 1'b1;
        rdata_error_i = 1'b0;
        repeat (4) tick();
        err_clr_n = 1'b0;
        repeat (5) tick();
        check("clear_ok_led", {7'd0, led_rdata_error}, 8'd0);
        check("clear_ok_count", err_count, 8'd1);
        $display("clear: led=%0b count=%0d", led_rdata_error, err_count);
        err_clr_n = 1'b1;
        repeat (3) tick();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            rdata_error_i = 1'b1;
            tick();
            rdata_error_i = 1'b0;
            err_clr_n = 1'b0;
            tick();
            err_clr_n = 1'b1;
            repeat (5) tick();
        end
        check("saturate_255", err_count, 8'd255);
        rdata_error_i = 1'b1;
        repeat (4) tick();
        rdata_error_i = 1'b0;
        check("saturate_hold", err_count, 8'd255);
        $display("saturation: err_count=%0d", err_count);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            pll_lock      = ($urandom_range(0, 19) != 0);
            rdata_error_i = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) fifo_full_i  = ~fifo_full_i;
            if ($urandom_range(0, 5) == 0) fifo_empty_i = ~fifo_empty_i;
            err_clr_n     = ($urandom_range(0, 3) != 0);
            tick();
        end
        $display("random: 400 cycles, err_count=%0d", err_count);

        // Reset in FAULT and mid-stretch
        pll_lock = 1'b1; err_clr_n = 1'b1; fifo_empty_i = 1'b0;
        rdata_error_i = 1'b1; fifo_full_i = 1'b1;
        repeat (4) tick();
        rdata_error_i = 1'b0; fifo_full_i = 1'b0;
        tick();
        check("pre_reset_fault", {7'd0, led_rdata_error}, 8'd1);
        check("pre_reset_stretch", {7'd0, led_fifo_full}, 8'd1);
        async_reset();
        repeat (3) tick();
        check("post_reset_count", err_count, 8'd0);
        check("post_reset_run", {7'd0, led_rdata_error}, 8'd0);
        $display("mid reset: err_count=%0d fault=%0b", err_count, led_rdata_error);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
